// File: rtl/serv_dbus_if_if.sv
// Request, response and Wishbone signals of the data-bus sequencer.
// The sequencer itself takes the master view; its environment takes the slave view.
interface serv_dbus_if_if;
    logic        i_req;
    logic        i_we;
    logic [1:0]  i_size;
    logic [31:0] i_adr;
    logic [31:0] i_wdat;
    logic [31:0] o_rdat;
    logic        o_load;
    logic        o_done;
    logic        o_misalign;
    logic        o_err;
    logic        o_busy;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;
    logic        i_wb_err;

    modport master (
        input  i_req, i_we, i_size, i_adr, i_wdat, i_wb_rdt, i_wb_ack, i_wb_err,
        output o_rdat, o_load, o_done, o_misalign, o_err, o_busy,
               o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb
    );

    modport slave (
        output i_req, i_we, i_size, i_adr, i_wdat, i_wb_rdt, i_wb_ack, i_wb_err,
        input  o_rdat, o_load, o_done, o_misalign, o_err, o_busy,
               o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb
    );
endinterface

// File: rtl/serv_dbus_if.sv
// Data-bus sequencer: turns one load/store request into one Wishbone classic
// cycle and reports completion, misalignment and bus errors.
module serv_dbus_if #(
    parameter int unsigned WITH_MISALIGN = 1,
    parameter int unsigned TIMEOUT_W     = 0
) (
    input logic            i_clk,
    input logic            i_rst_n,
    serv_dbus_if_if.master bus
);
    localparam int unsigned CNT_W = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;

    typedef enum logic {IDLE, BUS} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               misalign_c;
    logic [3:0]         sel_c;
    logic               timeout_c;

    // Byte enables and alignment check decoded from the incoming request
    always_comb begin
        misalign_c = 1'b0;
        sel_c      = 4'b1111;
        case (bus.i_size)
            2'b00: sel_c = 4'b0001 << bus.i_adr[1:0];
            2'b01: begin
                sel_c      = bus.i_adr[1] ? 4'b1100 : 4'b0011;
                misalign_c = bus.i_adr[0];
            end
            default: misalign_c = |bus.i_adr[1:0];
        endcase
    end

    assign timeout_c = (TIMEOUT_W != 0) && (cnt == {CNT_W{1'b1}});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.o_wb_cyc   <= 1'b0;
            bus.o_wb_stb   <= 1'b0;
            bus.o_wb_we    <= 1'b0;
            bus.o_wb_adr   <= '0;
            bus.o_wb_dat   <= '0;
            bus.o_wb_sel   <= '0;
            bus.o_rdat     <= '0;
            bus.o_load     <= 1'b0;
            bus.o_done     <= 1'b0;
            bus.o_misalign <= 1'b0;
            bus.o_err      <= 1'b0;
            bus.o_busy     <= 1'b0;
        end else begin
            bus.o_load     <= 1'b0;
            bus.o_done     <= 1'b0;
            bus.o_misalign <= 1'b0;
            bus.o_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_req) begin
                        if ((WITH_MISALIGN != 0) && misalign_c) begin
                            // Trap without touching the bus
                            bus.o_done     <= 1'b1;
                            bus.o_misalign <= 1'b1;
                        end else begin
                            bus.o_wb_adr <= {bus.i_adr[31:2], 2'b00};
                            bus.o_wb_dat <= bus.i_wdat;
                            bus.o_wb_sel <= sel_c;
                            bus.o_wb_we  <= bus.i_we;
                            bus.o_wb_cyc <= 1'b1;
                            bus.o_wb_stb <= 1'b1;
                            bus.o_busy   <= 1'b1;
                            cnt          <= '0;
                            state        <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (bus.i_wb_err || timeout_c) begin
                        // Error beats ack; read data is discarded
                        bus.o_wb_cyc <= 1'b0;
                        bus.o_wb_stb <= 1'b0;
                        bus.o_busy   <= 1'b0;
                        bus.o_err    <= 1'b1;
                        bus.o_done   <= 1'b1;
                        state        <= IDLE;
                    end else if (bus.i_wb_ack) begin
                        bus.o_wb_cyc <= 1'b0;
                        bus.o_wb_stb <= 1'b0;
                        bus.o_busy   <= 1'b0;
                        bus.o_done   <= 1'b1;
                        if (!bus.o_wb_we) begin
                            bus.o_rdat <= bus.i_wb_rdt;
                            bus.o_load <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/serv_dbus_if.md
Name: serv_dbus_if

Overview:
Data-bus sequencer between the serial buffer register and the Wishbone data port. It accepts a load/store request carrying address, size and the 32-bit store word already lane-aligned by the buffer register, then runs one Wishbone classic cycle. It returns the raw read word with a one-cycle load strobe for the buffer register's parallel load, and it reports completion, misalignment and bus errors to the control/state logic.

Parameters:
WITH_MISALIGN, 1, 1 = detect misaligned half/word accesses and trap without a bus cycle; 0 = never flag, always issue the cycle.
TIMEOUT_W, 0, width of the ack-timeout counter; 0 = no timeout.

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req  in  1  start request, sampled only in IDLE
i_we  in  1  1 = store, 0 = load
i_size  in  2  00 byte, 01 half, 1x word
i_adr  in  32  byte address
i_wdat  in  32  store data, lanes already positioned
o_rdat  out  32  captured read word
o_load  out  1  one-cycle strobe: o_rdat valid this cycle
o_done  out  1  one-cycle completion pulse
o_misalign  out  1  one-cycle pulse coincident with o_done
o_err  out  1  one-cycle bus-error/timeout pulse coincident with o_done
o_busy  out  1  high in BUS state
o_wb_adr  out  32  {adr[31:2],2'b00}
o_wb_dat  out  32  registered store data
o_wb_sel  out  4  byte enables
o_wb_we  out  1  write enable
o_wb_cyc  out  1  cycle
o_wb_stb  out  1  strobe, equal to cyc
i_wb_rdt  in  32  read data
i_wb_ack  in  1  acknowledge
i_wb_err  in  1  bus error

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_wb_cyc/stb/we=0; o_wb_adr, o_wb_dat, o_wb_sel, o_rdat=0; o_load, o_done, o_misalign, o_err, o_busy=0; timeout counter=0. Reset during BUS drops cyc/stb immediately, and no pulses are produced.
- Misalignment: half access with adr[0]=1; word access with adr[1:0]!=0. Byte accesses are never misaligned.
- sel: byte = 4'b0001<<adr[1:0]; half = adr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
- IDLE, i_req=1, misaligned and WITH_MISALIGN=1: on the next cycle o_done=o_misalign=1 for one cycle. No bus cycle. Stay in IDLE.
- IDLE, i_req=1, otherwise: register adr, sel, we and wdat. Move to BUS. cyc/stb/busy go high on the next cycle (latency 1).
- BUS: adr, dat, sel and we are held stable. i_req is ignored. The counter increments each cycle without ack or err.
- BUS, i_wb_err=1 (wins over a simultaneous ack): next cycle cyc/stb=0, o_err=o_done=1 for one cycle, no o_load, and o_rdat is unchanged. Go to IDLE.
- BUS, TIMEOUT_W>0, counter reaches 2^TIMEOUT_W-1 with no ack or err: treated exactly as err.
- BUS, i_wb_ack=1 and no err: next cycle cyc/stb=0 and o_done=1. For a load, o_rdat<=i_wb_rdt and o_load=1 in that same cycle. For a store, o_rdat is unchanged and o_load=0. Go to IDLE.
- Back-to-back: after a completion, IDLE can accept i_req in the done cycle itself. cyc therefore has a minimum one-cycle low gap between transactions.
- o_rdat holds its value until the next successful load.
- No lane shifting or sign extension: the buffer register selects the lane using lsb and the memory interface handles extension.
- o_misalign and o_err are never asserted together. o_load implies o_done.

Test Plan:
- Reset mid-BUS: issue a word load to 0x100, deassert i_rst_n while cyc=1 -> cyc/stb drop asynchronously; o_done, o_load and o_rdat stay 0 after release.
- Byte store, adr=0x1003, wdat=0xAB000000 -> one cycle later cyc=stb=we=1, wb_adr=0x1000, sel=4'b1000, wb_dat=0xAB000000. Ack after 3 wait states -> the next cycle has o_done=1, o_load=0 and cyc=0.
- Word load, adr=0x2000, ack with rdt=0xDEADBEEF -> the next cycle has o_load=o_done=1 and o_rdat=0xDEADBEEF; o_rdat is still 0xDEADBEEF 5 cycles later.
- Half load at adr=0x2001 with WITH_MISALIGN=1 -> cyc stays 0; o_done=o_misalign=1 one cycle after the req. Repeat with WITH_MISALIGN=0 -> bus cycle with sel=4'b0011.
- Ack and err asserted in the same cycle for a load -> o_err=o_done=1, o_load=0, o_rdat unchanged.
- TIMEOUT_W=3, no ack -> o_err pulses 8 cycles after cyc rises; a back-to-back req in the done cycle raises cyc again exactly 1 cycle later.
